// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the PC and decode.
// Issues single-outstanding req/gnt/rvalid transactions, pulses PC_ADV on grant,
// and buffers {instr, pc} pairs in a 2-entry prefetch FIFO. FLUSH discards
// buffered entries and any in-flight fetch.
// Optional feature: define FETCH_PERF_CNT_EN to enable the fetch stall counter.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [31:0] PC_IN,
  output logic        PC_ADV,
  input  logic        FLUSH,
  output logic        INSTR_REQ,
  output logic [31:0] INSTR_ADDR,
  input  logic        INSTR_GNT,
  input  logic        INSTR_RVALID,
  input  logic [31:0] INSTR_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  input  logic        ID_READY,
  output logic [31:0] FETCH_STALL_CNT
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DROP_REQ,
    DROP_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_entry_t       fifo_q [FIFO_DEPTH];
  fifo_entry_t       fifo_d [FIFO_DEPTH];

  logic              empty;
  logic              pop;
  logic              push;
  logic [CNT_W-1:0]  occ_after;

  // Decode-side handshake and occupancy after this cycle's push/pop
  assign empty     = (count_q == '0);
  assign IF_VALID  = !empty && !FLUSH;
  assign pop       = IF_VALID && ID_READY;
  assign occ_after = count_q + CNT_W'(1) - CNT_W'(pop);

  assign INSTR_REQ  = (state_q == REQ) || (state_q == DROP_REQ);
  assign INSTR_ADDR = addr_q;
  assign PC_ADV     = (state_q == REQ) && INSTR_GNT && !FLUSH;
  assign IF_INSTR   = empty ? NOP_INSTR : fifo_q[rd_ptr_q].instr;
  assign IF_PC      = empty ? '0 : fifo_q[rd_ptr_q].pc;

  // Fetch FSM: next state, request address capture and push decision
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!FLUSH && (count_q < CNT_W'(FIFO_DEPTH))) begin
          state_d = REQ;
          addr_d  = PC_IN;
        end
      end
      REQ: begin
        if (INSTR_GNT) begin
          state_d = FLUSH ? DROP_RSP : WAIT;
        end else if (FLUSH) begin
          state_d = DROP_REQ;
        end
      end
      WAIT: begin
        if (INSTR_RVALID) begin
          push = !FLUSH;
          if (!FLUSH && (occ_after < CNT_W'(FIFO_DEPTH))) begin
            state_d = REQ;
            addr_d  = PC_IN;
          end else begin
            state_d = IDLE;
          end
        end else if (FLUSH) begin
          state_d = DROP_RSP;
        end
      end
      DROP_REQ: begin
        if (INSTR_GNT) begin
          state_d = DROP_RSP;
        end
      end
      DROP_RSP: begin
        if (INSTR_RVALID) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Prefetch FIFO pointer/count/data update; flush wins over push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    fifo_d   = fifo_q;
    if (FLUSH) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{instr: INSTR_RDATA, pc: addr_q};
        wr_ptr_d         = !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = !rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State, address and FIFO registers
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
      fifo_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      fifo_q   <= fifo_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall_ev;

  // Stall events: request not granted, or response still outstanding
  always_comb begin
    stall_ev    = (INSTR_REQ && !INSTR_GNT) ||
                  (((state_q == WAIT) || (state_q == DROP_RSP)) && !INSTR_RVALID);
    stall_cnt_d = stall_cnt_q;
    if (stall_ev) begin
      stall_cnt_d = stall_cnt_q + XLEN'(1);
    end
  end

  // Free-running stall counter, cleared only by reset
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign FETCH_STALL_CNT = stall_cnt_q;
`else
  assign FETCH_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a small instruction memory
// and PC model. Memory returns ~addr as the instruction word.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RES;
  logic [31:0] PC_IN;
  logic        PC_ADV;
  logic        FLUSH;
  logic        INSTR_REQ;
  logic [31:0] INSTR_ADDR;
  logic        INSTR_GNT;
  logic        INSTR_RVALID;
  logic [31:0] INSTR_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic        ID_READY;
  logic [31:0] FETCH_STALL_CNT;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_unit #(.FIFO_DEPTH(2)) dut (
    .CLK             (CLK),
    .RES             (RES),
    .PC_IN           (PC_IN),
    .PC_ADV          (PC_ADV),
    .FLUSH           (FLUSH),
    .INSTR_REQ       (INSTR_REQ),
    .INSTR_ADDR      (INSTR_ADDR),
    .INSTR_GNT       (INSTR_GNT),
    .INSTR_RVALID    (INSTR_RVALID),
    .INSTR_RDATA     (INSTR_RDATA),
    .IF_VALID        (IF_VALID),
    .IF_INSTR        (IF_INSTR),
    .IF_PC           (IF_PC),
    .ID_READY        (ID_READY),
    .FETCH_STALL_CNT (FETCH_STALL_CNT)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] rsp_addr;
  bit          pending;
  bit          rsp_en;
  bit          gnt_en;
  int unsigned wait_cnt;
  int unsigned gnt_delay;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    INSTR_RVALID = pending && rsp_en;
    INSTR_RDATA  = ~rsp_addr;
    INSTR_GNT    = INSTR_REQ && gnt_en && (wait_cnt >= gnt_delay);
  endtask

  // Advance one clock, updating the PC and memory models from pre-edge values
  task automatic step();
    logic adv, req, gnt, rv, fl;
    logic [31:0] a;
    #1;
    adv = PC_ADV; req = INSTR_REQ; gnt = INSTR_GNT; rv = INSTR_RVALID;
    fl = FLUSH; a = INSTR_ADDR;
    @(posedge CLK);
    if (fl) pc = target;
    else if (adv) pc = pc + 32'd4;
    if (rv) pending = 1'b0;
    if (req && gnt) begin
      pending  = 1'b1;
      rsp_addr = a;
      wait_cnt = 0;
    end else if (req) begin
      wait_cnt++;
    end
    #1;
    PC_IN = pc;
    drive_mem();
    #1;
  endtask

  task automatic do_reset();
    RES = 1'b1; FLUSH = 1'b0; ID_READY = 1'b1;
    pending = 1'b0; rsp_addr = '0; wait_cnt = 0; gnt_delay = 0;
    gnt_en = 1'b1; rsp_en = 1'b1;
    pc = 32'h1A00_0000; PC_IN = pc; target = '0;
    INSTR_GNT = 1'b0; INSTR_RVALID = 1'b0; INSTR_RDATA = '0;
    repeat (2) @(posedge CLK);
    #1;
    RES = 1'b0;
    drive_mem();
    #1;
  endtask

  initial begin
    // ---------------- reset values ----------------
    RES = 1'b1; FLUSH = 1'b0; ID_READY = 1'b1; PC_IN = 32'h1A00_0000;
    INSTR_GNT = 1'b0; INSTR_RVALID = 1'b0; INSTR_RDATA = '0;
    repeat (2) @(posedge CLK);
    #2;
    check("rst_req",   32'(INSTR_REQ), 32'd0);
    check("rst_addr",  INSTR_ADDR,     32'h0);
    check("rst_adv",   32'(PC_ADV),    32'd0);
    check("rst_valid", 32'(IF_VALID),  32'd0);
    check("rst_instr", IF_INSTR,       32'h0000_0013);
    check("rst_pc",    IF_PC,          32'h0);
    check("rst_stall", FETCH_STALL_CNT, 32'h0);

    // ---------------- reset fetch, zero-wait ----------------
    do_reset();
    step();
    check("s1_req1",  32'(INSTR_REQ), 32'd1);
    check("s1_addr1", INSTR_ADDR,     32'h1A00_0000);
    check("s1_adv1",  32'(PC_ADV),    32'd1);
    check("s1_val1",  32'(IF_VALID),  32'd0);
    step();
    check("s1_req2",  32'(INSTR_REQ), 32'd0);
    check("s1_adv2",  32'(PC_ADV),    32'd0);
    check("s1_val2",  32'(IF_VALID),  32'd0);
    step();
    check("s1_val3",  32'(IF_VALID),  32'd1);
    check("s1_pc3",   IF_PC,          32'h1A00_0000);
    check("s1_ins3",  IF_INSTR,       32'hE5FF_FFFF);
    check("s1_addr3", INSTR_ADDR,     32'h1A00_0004);
    check("s1_adv3",  32'(PC_ADV),    32'd1);
    step();
    check("s1_val4",  32'(IF_VALID),  32'd0);
    step();
    check("s1_val5",  32'(IF_VALID),  32'd1);
    check("s1_pc5",   IF_PC,          32'h1A00_0004);
    check("s1_ins5",  IF_INSTR,       32'hE5FF_FFFB);

    // ---------------- back-pressure ----------------
    do_reset();
    ID_READY = 1'b0;
    step(); step();
    step();
    check("s2_pc3",   IF_PC,          32'h1A00_0000);
    step(); step();
    check("s2_req5",  32'(INSTR_REQ), 32'd0);
    check("s2_adv5",  32'(PC_ADV),    32'd0);
    check("s2_pc5",   IF_PC,          32'h1A00_0000);
    step();
    check("s2_req6",  32'(INSTR_REQ), 32'd0);
    check("s2_adv6",  32'(PC_ADV),    32'd0);
    check("s2_val6",  32'(IF_VALID),  32'd1);
    ID_READY = 1'b1;
    step();
    check("s2_pc7",   IF_PC,          32'h1A00_0004);
    check("s2_ins7",  IF_INSTR,       32'hE5FF_FFFB);
    check("s2_req7",  32'(INSTR_REQ), 32'd0);
    step();
    check("s2_val8",  32'(IF_VALID),  32'd0);
    check("s2_req8",  32'(INSTR_REQ), 32'd1);
    check("s2_addr8", INSTR_ADDR,     32'h1A00_0008);

    // ---------------- flush in WAIT ----------------
    do_reset();
    step();
    rsp_en = 1'b0;
    step();
    FLUSH = 1'b1; target = 32'h1A00_0100;
    #1;
    check("s3_val_fl", 32'(IF_VALID), 32'd0);
    step();
    FLUSH = 1'b0; rsp_en = 1'b1; drive_mem();
    #1;
    check("s3_req_drop", 32'(INSTR_REQ), 32'd0);
    step();
    check("s3_val_disc", 32'(IF_VALID),  32'd0);
    check("s3_req_idle", 32'(INSTR_REQ), 32'd0);
    step();
    check("s3_req_tgt",  32'(INSTR_REQ), 32'd1);
    check("s3_addr_tgt", INSTR_ADDR,     32'h1A00_0100);
    check("s3_adv_tgt",  32'(PC_ADV),    32'd1);
    step(); step();
    check("s3_pc_tgt",   IF_PC,          32'h1A00_0100);
    check("s3_ins_tgt",  IF_INSTR,       32'hE5FF_FEFF);
    // flush with a buffered entry and a granted request
    ID_READY = 1'b0; FLUSH = 1'b1; target = 32'h1A00_0200;
    #1;
    check("s3_val_mask", 32'(IF_VALID),  32'd0);
    check("s3_adv_mask", 32'(PC_ADV),    32'd0);
    step();
    FLUSH = 1'b0;
    #1;
    check("s3_val_clr",  32'(IF_VALID),  32'd0);
    check("s3_req_clr",  32'(INSTR_REQ), 32'd0);
    step();
    check("s3_val_drop", 32'(IF_VALID),  32'd0);
    step();
    check("s3_addr2",    INSTR_ADDR,     32'h1A00_0200);
    check("s3_req2",     32'(INSTR_REQ), 32'd1);

    // ---------------- flush in REQ, grant delayed ----------------
    do_reset();
    gnt_en = 1'b0; drive_mem();
    step();
    FLUSH = 1'b1; target = 32'h1A00_0300;
    #1;
    check("s4_adv0",  32'(PC_ADV),    32'd0);
    step();
    FLUSH = 1'b0;
    #1;
    check("s4_req1",  32'(INSTR_REQ), 32'd1);
    check("s4_addr1", INSTR_ADDR,     32'h1A00_0000);
    check("s4_adv1",  32'(PC_ADV),    32'd0);
    step();
    check("s4_req2",  32'(INSTR_REQ), 32'd1);
    check("s4_addr2", INSTR_ADDR,     32'h1A00_0000);
    gnt_en = 1'b1; drive_mem();
    #1;
    check("s4_adv3",  32'(PC_ADV),    32'd0);
    check("s4_addr3", INSTR_ADDR,     32'h1A00_0000);
    step();
    check("s4_req4",  32'(INSTR_REQ), 32'd0);
    step();
    check("s4_val5",  32'(IF_VALID),  32'd0);
    step();
    check("s4_addr6", INSTR_ADDR,     32'h1A00_0300);
    check("s4_req6",  32'(INSTR_REQ), 32'd1);

    // ---------------- async reset mid-WAIT ----------------
    do_reset();
    ID_READY = 1'b0;
    step(); step(); step();
    rsp_en = 1'b0;
    step();
    check("s5_val_pre", 32'(IF_VALID), 32'd1);
    #2;
    RES = 1'b1;
    #1;
    check("s5_req_rst",   32'(INSTR_REQ), 32'd0);
    check("s5_val_rst",   32'(IF_VALID),  32'd0);
    check("s5_addr_rst",  INSTR_ADDR,     32'h0);
    check("s5_instr_rst", IF_INSTR,       32'h0000_0013);
    @(posedge CLK);
    #1;
    RES = 1'b0; rsp_en = 1'b1; drive_mem();
    #1;
    step();
    check("s5_val_late", 32'(IF_VALID),  32'd0);
    check("s5_req_new",  32'(INSTR_REQ), 32'd1);
    check("s5_addr_new", INSTR_ADDR,     32'h1A00_0008);
    step(); step();
    check("s5_val_new",  32'(IF_VALID),  32'd1);
    check("s5_pc_new",   IF_PC,          32'h1A00_0008);
    check("s5_ins_new",  IF_INSTR,       32'hE5FF_FFF7);

    // ---------------- stall counter ----------------
    do_reset();
    gnt_delay = 4; drive_mem();
    step();
    check("s6_cnt0", FETCH_STALL_CNT, 32'd0);
    step(); step();
    check("s6_cnt2", FETCH_STALL_CNT, PERF ? 32'd2 : 32'd0);
    step(); step();
    check("s6_adv",  32'(PC_ADV),     32'd1);
    step();
    check("s6_cnt4", FETCH_STALL_CNT, PERF ? 32'd4 : 32'd0);
    step();
    check("s6_cnt4b", FETCH_STALL_CNT, PERF ? 32'd4 : 32'd0);
    check("s6_pc",    IF_PC,           32'h1A00_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
